// File: rtl/mc_datapath_gen2.sv
// rtl/mc_datapath_gen2.sv - multi-cycle 16-bit-encoded datapath with shared memory port
// FETCH/DECODE/EXEC/MEM/WB sequencer, register file, ALU with {F,N,C,Z} flags.
module mc_datapath_gen2 #(
    parameter int                DATA_W    = 16,
    parameter int                REG_COUNT = 16,
    parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        psr,
    output logic [DATA_W-1:0] pc,
    output logic              halted
);

    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [3:0]        psr_q, psr_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];

    logic [3:0]        op_f, rd_f, ext_f;
    logic [IDX_W-1:0]  rd_idx, rs_idx;
    logic [DATA_W-1:0] imm_ext;
    logic              is_rtype, is_itype, is_alu, is_load, is_stor, is_br, is_cmp, legal;
    logic [3:0]        alu_code;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W:0]   sum, dif;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_psr;
    logic              br_taken;
    logic [DATA_W-1:0] pc_inc, br_target;
    logic              req_c, we_c;
    logic [DATA_W-1:0] addr_c;

    function automatic logic is_alu_code(input logic [3:0] c);
        case (c)
            4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: is_alu_code = 1'b1;
            default: is_alu_code = 1'b0;
        endcase
    endfunction

    assign op_f    = ir_q[15:12];
    assign rd_f    = ir_q[11:8];
    assign ext_f   = ir_q[7:4];
    assign rd_idx  = IDX_W'(int'(ir_q[11:8]) % REG_COUNT);
    assign rs_idx  = IDX_W'(int'(ir_q[3:0]) % REG_COUNT);
    assign imm_ext = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

    // I-type opcodes reuse the R-type ext codes, so both share one ALU selector.
    assign is_rtype = (op_f == 4'b0000) && is_alu_code(ext_f);
    assign is_itype = is_alu_code(op_f);
    assign is_alu   = is_rtype || is_itype;
    assign alu_code = is_rtype ? ext_f : op_f;
    assign is_cmp   = is_alu && (alu_code == 4'b1011);
    assign is_load  = (op_f == 4'b0100) && (ext_f == 4'b0000);
    assign is_stor  = (op_f == 4'b0100) && (ext_f == 4'b0100);
    assign is_br    = (op_f == 4'b1100) &&
                      ((rd_f == 4'b0000) || (rd_f == 4'b0001) || (rd_f == 4'b1110));
    assign legal    = is_alu || is_load || is_stor || is_br;

    assign opnd = is_itype ? imm_ext : b_q;
    assign sum  = {1'b0, a_q} + {1'b0, opnd};
    assign dif  = {1'b0, a_q} - {1'b0, opnd};

    always_comb begin
        alu_res = '0;
        alu_psr = psr_q;
        case (alu_code)
            4'b0101: begin
                alu_res    = sum[DATA_W-1:0];
                alu_psr[1] = sum[DATA_W];
                alu_psr[3] = (a_q[MSB] == opnd[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            4'b1001, 4'b1011: begin
                alu_res    = dif[DATA_W-1:0];
                alu_psr[1] = dif[DATA_W];
                alu_psr[3] = (a_q[MSB] != opnd[MSB]) && (dif[MSB] != a_q[MSB]);
            end
            4'b0001: alu_res = a_q & opnd;
            4'b0010: alu_res = a_q | opnd;
            4'b0011: alu_res = a_q ^ opnd;
            4'b1101: alu_res = opnd;
            default: alu_res = '0;
        endcase
        alu_psr[0] = (alu_res == '0);
        alu_psr[2] = alu_res[MSB];
    end

    always_comb begin
        case (rd_f)
            4'b0000: br_taken = psr_q[0];
            4'b0001: br_taken = ~psr_q[0];
            default: br_taken = 1'b1;
        endcase
    end

    assign pc_inc    = pc_q + DATA_W'(1);
    assign br_target = pc_inc + imm_ext;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        psr_d   = psr_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = pc_q;
        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = regs_q[rd_idx];
                b_d     = regs_q[rs_idx];
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                if (is_br) begin
                    pc_d    = br_taken ? br_target : pc_inc;
                    state_d = FETCH;
                end else begin
                    pc_d = pc_inc;
                    if (is_alu) begin
                        res_d   = alu_res;
                        psr_d   = alu_psr;
                        state_d = WB;
                    end else begin
                        state_d = MEM;
                    end
                end
            end
            MEM: begin
                req_c  = 1'b1;
                we_c   = is_stor;
                addr_c = b_q;
                if (mem_ack) begin
                    if (is_load) begin
                        res_d   = mem_rdata;
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            psr_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            psr_q   <= psr_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Register file has no reset; WB never coincides with reset since state is forced to FETCH.
    always_ff @(posedge clk) begin
        if (state_q == WB && !is_cmp) begin
            regs_q[rd_idx] <= res_q;
        end
    end

    // Reset gates the request combinationally so an in-flight access is dropped at once.
    assign mem_req   = req_c & ~reset;
    assign mem_we    = we_c & ~reset;
    assign mem_addr  = addr_c;
    assign mem_wdata = a_q;
    assign psr       = psr_q;
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);

endmodule

// File: doc/mc_datapath_gen2.md
MC_DATAPATH_GEN2 -- requirements
Module: mc_datapath_gen2

Interface
REQ-001 Parameter DATA_W, default 16: datapath/register/PC/address width; legal 16..64.
REQ-002 Parameter REG_COUNT, default 16: register-file depth; legal 2..16; instruction register fields index modulo REG_COUNT.
REQ-003 Parameter RESET_PC, default 0: PC value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 mem_req  output  1  memory access request; held until mem_ack.
REQ-007 mem_we  output  1  1=write, 0=read; valid while mem_req=1.
REQ-008 mem_addr  output  DATA_W  access address; stable while mem_req=1.
REQ-009 mem_wdata  output  DATA_W  store data; stable while mem_req=1.
REQ-010 mem_rdata  input  DATA_W  read data; sampled on the edge where mem_ack=1.
REQ-011 mem_ack  input  1  access complete; ignored when mem_req=0.
REQ-012 psr  output  4  flags {F,N,C,Z}, registered.
REQ-013 pc  output  DATA_W  current PC.
REQ-014 halted  output  1  1 after illegal instruction until reset.

Function
REQ-015 Instruction = mem_rdata[15:0]: op[15:12], rd[11:8], ext[7:4], rs[3:0]; imm8=[7:0] sign-extended to DATA_W.
REQ-016 op 0000 (R-type) by ext: 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV; rd <- rd op rs (CMP/MOV as below).
REQ-017 I-type op = R-type ext code (0101 ADDI, 1001 SUBI, 1011 CMPI, 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI) with imm8 as second operand.
REQ-018 op 0100: ext 0000 LOAD rd <- mem[rs]; ext 0100 STOR mem[rs] <- rd.
REQ-019 op 1100 branch, cond in rd: 0000 Z=1, 0001 Z=0, 1110 always; taken -> PC <- PC+1+imm8; not taken -> PC+1.
REQ-020 Any other encoding is illegal: enter HALT, no register/flag/PC update.
REQ-021 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; reset state FETCH.
REQ-022 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack latch IR, go DECODE; otherwise stay.
REQ-023 DECODE: latch A<-R[rd], B<-R[rs]; illegal -> HALT; else EXEC.
REQ-024 EXEC: ALU/branch evaluate; PC <- PC+1 (or branch target); ALU ops -> WB; LOAD/STOR -> MEM; branch -> FETCH.
REQ-025 MEM: mem_req=1, mem_addr=B, mem_we=1 for STOR with mem_wdata=A; on mem_ack LOAD -> WB (data latched), STOR -> FETCH.
REQ-026 WB: write rd (ALU result or loaded word); CMP/CMPI write nothing; -> FETCH.
REQ-027 Latency with mem_ack=1 in the first request cycle: ALU op 4 cycles, branch 3, STOR 4, LOAD 5; each ack wait cycle adds one.
REQ-028 Arithmetic modulo 2^DATA_W; PC wraps from all-ones to 0.
REQ-029 ADD/SUB/CMP (and immediates) update all flags: Z=result==0, N=result MSB, C=carry out (ADD) or borrow (SUB/CMP, B>A unsigned), F=signed overflow.
REQ-030 Logic ops and MOV update Z,N only; C,F hold. LOAD/STOR/branch leave flags unchanged.
REQ-031 Flags and PC update at the EXEC edge; register write at the WB edge.
REQ-032 HALT: mem_req=0, halted=1, all state frozen until reset.
REQ-033 mem_req deasserts the cycle after the accepting mem_ack.

Reset
REQ-034 On reset: pc=RESET_PC, psr=0, halted=0, mem_req=0, mem_we=0, IR/A/B=0, state FETCH; register file contents undefined.
REQ-035 reset asserted mid-access aborts the access combinationally (mem_req=0); first request after release is a fetch at RESET_PC.

Verification
REQ-036 MOVI r1,#5; ADDI r1,#-1 x5; BNE -2, zero-wait memory -> r1=0, Z=1, loop exits, 4-cycle ALU spacing observed.
REQ-037 DATA_W=16: MOVI r2,#-1 (0xFFFF); ADDI r2,#1 -> r2=0x0000, C=1, Z=1, F=0; MOVI r3,#0x7F; ADD r3,r3 x9 -> F=1 on signed wrap.
REQ-038 STOR r4->[r5] then LOAD r6<-[r5] with mem_ack delayed 3 cycles -> r6=r4, mem_addr/mem_wdata stable throughout request.
REQ-039 Instruction 0xF000 -> halted=1, mem_req=0 forever, pc/psr unchanged; reset -> fetch at RESET_PC.
REQ-040 Assert reset during a LOAD wait -> outputs at reset values that cycle; load never written.
REQ-041 DATA_W=32, REG_COUNT=8: branch at pc=0xFFFFFFFF with always-cond, imm8=0 -> pc=0x00000000.
